// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC, issues instruction-memory reads and
// holds each fetched word for decode until it is allowed to advance.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        misalign_err,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        pend_q, pend_d;
    logic [31:0] ptgt_q, ptgt_d;

    // A redirect arriving on the same edge as imem_ready wins over an older one.
    logic        pend_eff;
    logic [31:0] ptgt_eff;

    assign pend_eff = pend_q | redirect_valid;
    assign ptgt_eff = redirect_valid ? redirect_target : ptgt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            instr_q <= 32'h0;
            cnt_q   <= 32'h0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            ptgt_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            ptgt_q  <= ptgt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pend_d  = pend_q;
        ptgt_d  = ptgt_q;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect_valid) begin
                    pend_d = 1'b1;
                    ptgt_d = redirect_target;
                end
                if (imem_ready) begin
                    if (pend_eff) begin
                        pend_d = 1'b0;
                        if (ptgt_eff[1:0] != 2'b00) begin
                            err_d   = 1'b1;
                            state_d = HALTED;
                        end else begin
                            pc_d = ptgt_eff;
                        end
                    end else begin
                        instr_d = imem_rdata;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!stall) begin
                    cnt_d = cnt_q + 32'd1;
                    if (halt) begin
                        state_d = HALTED;
                    end else if (redirect_valid) begin
                        if (redirect_target[1:0] != 2'b00) begin
                            err_d   = 1'b1;
                            state_d = HALTED;
                        end else begin
                            pc_d    = redirect_target;
                            state_d = FETCH;
                        end
                    end else begin
                        pc_d    = pc_q + 32'd4;
                        state_d = FETCH;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pc           = pc_q;
    assign imem_addr    = pc_q;
    assign imem_req     = (state_q == FETCH);
    assign instr        = instr_q;
    assign instr_valid  = (state_q == ISSUE);
    assign misalign_err = err_q;
    assign retire_cnt   = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic
// checked against a transaction-level model of the fetch sequencer.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        halt = 1'b0;

    logic [31:0] pc, imem_addr, instr, retire_cnt;
    logic        imem_req, instr_valid, misalign_err;
    logic [31:0] pcw, imem_addrw, instrw, retire_cntw;
    logic        imem_reqw, instr_validw, misalign_errw;

    int vectors = 0;
    int miscompares = 0;

    // model: which phase the sequencer is in, plus architectural values
    bit          m_idle, m_fetch, m_issue, m_halt, m_err, m_pend;
    logic [31:0] m_pc, m_instr, m_cnt, m_ptgt;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .halt(halt),
        .misalign_err(misalign_err), .retire_cnt(retire_cnt)
    );

    pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .pc(pcw), .imem_req(imem_reqw),
        .imem_addr(imem_addrw), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instr(instrw), .instr_valid(instr_validw),
        .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .halt(halt),
        .misalign_err(misalign_errw), .retire_cnt(retire_cntw)
    );

    function automatic logic [130:0] dut_vec();
        return {pc, imem_addr, instr, instr_valid, imem_req,
                misalign_err, retire_cnt};
    endfunction

    function automatic logic [130:0] mdl_vec();
        return {m_pc, m_pc, m_instr, logic'(m_issue), logic'(m_fetch),
                logic'(m_err), m_cnt};
    endfunction

    task automatic model_reset();
        m_idle = 1; m_fetch = 0; m_issue = 0; m_halt = 0;
        m_err = 0; m_pend = 0;
        m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0; m_ptgt = 32'h0;
    endtask

    task automatic model_edge();
        if (m_idle) begin
            m_idle = 0;
            m_fetch = 1;
        end else if (m_fetch) begin
            if (redirect_valid) begin
                m_pend = 1;
                m_ptgt = redirect_target;
            end
            if (imem_ready) begin
                if (m_pend) begin
                    m_pend = 0;
                    if (m_ptgt % 4 != 0) begin
                        m_err = 1; m_fetch = 0; m_halt = 1;
                    end else begin
                        m_pc = m_ptgt;
                    end
                end else begin
                    m_instr = imem_rdata;
                    m_fetch = 0;
                    m_issue = 1;
                end
            end
        end else if (m_issue && !stall) begin
            m_cnt = m_cnt + 1;
            m_issue = 0;
            if (halt) begin
                m_halt = 1;
            end else if (redirect_valid && redirect_target % 4 != 0) begin
                m_err = 1;
                m_halt = 1;
            end else begin
                m_pc = redirect_valid ? redirect_target : m_pc + 4;
                m_fetch = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet_inputs();
        imem_ready = 0; stall = 0; redirect_valid = 0; halt = 0;
        redirect_target = 0; imem_rdata = $urandom;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        quiet_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic goto_issue();
        imem_ready = 1;
        for (int i = 0; i < 20 && !m_issue; i++) begin
            imem_rdata = $urandom;
            step();
        end
        vectors++;
        if (instr_valid !== 1'b1 || !m_issue) begin
            miscompares++;
            $display("FAIL goto_issue: instr_valid=%b required 1 (timeout)",
                     instr_valid);
        end
        imem_ready = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0;
        quiet_inputs();
        model_reset();
        #1;
        vectors++;
        if (dut_vec() !== mdl_vec()) begin
            miscompares++;
            $display("FAIL reset_vals: got %h required %h", dut_vec(), mdl_vec());
        end
        vectors++;
        if ({pc, imem_req, instr_valid, retire_cnt, instr} !==
            {32'h0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_const: pc=%h req=%b v=%b cnt=%h instr=%h",
                     pc, imem_req, instr_valid, retire_cnt, instr);
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL req_before_edge: got %b required 0", imem_req);
        end
        step();
        vectors++;
        if (imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL first_req: got %b required 1", imem_req);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        imem_ready = 1;
        for (int i = 0; i < 8; i++) begin
            imem_rdata = $urandom;
            step();
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL seq_cycle%0d: got %h required %h",
                         i, dut_vec(), mdl_vec());
            end
        end
        vectors++;
        if ({pc, retire_cnt, instr_valid} !== {32'hC, 32'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL seq_end: pc=%h cnt=%0d v=%b required C/3/1",
                     pc, retire_cnt, instr_valid);
        end
    endtask

    task automatic test_mem_wait();
        logic [31:0] word;
        do_reset();
        imem_ready = 1;
        for (int i = 0; i < 3; i++) step();
        imem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            imem_rdata = $urandom;
            step();
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h4 ||
                dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL wait_hold%0d: req=%b addr=%h got %h required %h",
                         i, imem_req, imem_addr, dut_vec(), mdl_vec());
            end
        end
        word = $urandom;
        imem_rdata = word;
        imem_ready = 1;
        step();
        vectors++;
        if (instr !== word || instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_sample: instr=%h v=%b required %h/1",
                     instr, instr_valid, word);
        end
    endtask

    task automatic test_stall_redirect();
        do_reset();
        goto_issue();
        stall = 1;
        redirect_valid = 1;
        redirect_target = 32'h100;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (pc !== 32'h0 || instr_valid !== 1'b1 ||
                dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL stall_hold%0d: pc=%h v=%b required 0/1",
                         i, pc, instr_valid);
            end
        end
        stall = 0;
        step();
        vectors++;
        if (pc !== 32'h100 || retire_cnt !== 32'd1 || imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: pc=%h cnt=%0d req=%b required 100/1/1",
                     pc, retire_cnt, imem_req);
        end
        redirect_valid = 0;
    endtask

    task automatic test_fetch_redirect();
        logic [31:0] old_instr;
        do_reset();
        goto_issue();
        step();
        old_instr = instr;
        imem_ready = 0;
        redirect_valid = 1;
        redirect_target = 32'h40;
        step();
        redirect_valid = 0;
        imem_ready = 1;
        imem_rdata = ~old_instr;
        step();
        vectors++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 ||
            imem_addr !== 32'h40 || retire_cnt !== 32'd1 ||
            instr !== old_instr) begin
            miscompares++;
            $display("FAIL fetch_redirect: v=%b req=%b addr=%h cnt=%0d instr=%h",
                     instr_valid, imem_req, imem_addr, retire_cnt, instr);
        end
        vectors++;
        if (dut_vec() !== mdl_vec()) begin
            miscompares++;
            $display("FAIL fetch_redirect_mdl: got %h required %h",
                     dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_misalign();
        do_reset();
        goto_issue();
        redirect_valid = 1;
        redirect_target = 32'h102;
        step();
        vectors++;
        if (misalign_err !== 1'b1 || imem_req !== 1'b0 ||
            instr_valid !== 1'b0 || pc !== 32'h0 || retire_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL misalign: err=%b req=%b v=%b pc=%h cnt=%0d",
                     misalign_err, imem_req, instr_valid, pc, retire_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            imem_ready = 1'($urandom);
            stall = 1'($urandom);
            redirect_valid = 1'($urandom);
            redirect_target = $urandom;
            step();
            vectors++;
            if (imem_req !== 1'b0 || dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL halted_frozen%0d: got %h required %h",
                         i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        goto_issue();
        halt = 1;
        step();
        halt = 0;
        vectors++;
        if (retire_cnt !== 32'd1 || imem_req !== 1'b0 ||
            instr_valid !== 1'b0 || misalign_err !== 1'b0 || pc !== 32'h0) begin
            miscompares++;
            $display("FAIL halt: cnt=%0d req=%b v=%b err=%b pc=%h",
                     retire_cnt, imem_req, instr_valid, misalign_err, pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        imem_ready = 1;
        vectors++;
        if (pcw !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_reset_pc: got %h required FFFFFFFC", pcw);
        end
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if (pcw !== 32'h0 || retire_cntw !== 32'd1 || imem_reqw !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_pc: pc=%h cnt=%0d req=%b required 0/1/1",
                     pcw, retire_cntw, imem_reqw);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        imem_ready = 0;
        step();
        step();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        vectors++;
        if (imem_req !== 1'b0 || dut_vec() !== mdl_vec()) begin
            miscompares++;
            $display("FAIL async_reset: got %h required %h", dut_vec(), mdl_vec());
        end
        vectors++;
        if (pcw !== 32'hFFFF_FFFC || imem_reqw !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_w: pc=%h req=%b", pcw, imem_reqw);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < 250; i++) begin
                imem_ready = ($urandom_range(0, 99) < 70);
                stall = ($urandom_range(0, 99) < 30);
                redirect_valid = ($urandom_range(0, 99) < 15);
                redirect_target = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                if ($urandom_range(0, 99) < 10)
                    redirect_target[1:0] = 2'($urandom_range(1, 3));
                halt = ($urandom_range(0, 99) < 3);
                imem_rdata = $urandom;
                step();
                vectors++;
                if (dut_vec() !== mdl_vec()) begin
                    miscompares++;
                    $display("FAIL random r%0d c%0d: got %h required %h",
                             r, i, dut_vec(), mdl_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_mem_wait();
        test_stall_redirect();
        test_fetch_redirect();
        test_misalign();
        test_halt();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
